// File: rtl/custom_reg_arbiter.sv
// Round-robin write arbiter for a small bank of IP registers.
// Each transaction is granted, written, given RB_LAT cycles to settle, read
// back and compared, then reported through a response handshake.
module custom_reg_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 3,
    parameter int DATA_W   = 32,
    parameter int RB_LAT   = 2
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic [NUM_REQ-1:0]                             req_valid_i,
    input  logic [NUM_REQ*2-1:0]                           req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]                      req_data_i,
    output logic [NUM_REQ-1:0]                             req_ready_o,
    output logic [DATA_W-1:0]                              reg_wdata_o,
    output logic [NUM_REGS-1:0]                            reg_wen_o,
    input  logic [NUM_REGS*DATA_W-1:0]                     reg_rdata_i,
    output logic                                           rsp_valid_o,
    input  logic                                           rsp_ready_i,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] rsp_id_o,
    output logic                                           rsp_err_o,
    output logic [DATA_W-1:0]                              rsp_rdata_o,
    output logic                                           busy_o
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (RB_LAT > 1) ? $clog2(RB_LAT) : 1;
    // Value loaded into the settle counter; WAIT lasts (load + 1) cycles.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((RB_LAT > 0) ? (RB_LAT - 1) : 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [ID_W-1:0]    ptr_reg;
    logic [ID_W-1:0]    id_reg;
    logic [1:0]         addr_reg;
    logic [DATA_W-1:0]  data_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               err_reg;
    logic [DATA_W-1:0]  rdata_reg;

    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic               addr_ok;
    logic [DATA_W-1:0]  slot_sel;

    // Unpacked views of the flattened request and readback buses.
    logic [1:0]         req_addr [NUM_REQ];
    logic [DATA_W-1:0]  req_data [NUM_REQ];
    logic [DATA_W-1:0]  slot_rdata [NUM_REGS];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign req_addr[gi] = req_addr_i[gi*2 +: 2];
        assign req_data[gi] = req_data_i[gi*DATA_W +: DATA_W];
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_slot
        assign slot_rdata[gi] = reg_rdata_i[gi*DATA_W +: DATA_W];
    end

    // Slot addresses at or beyond NUM_REGS have no backing register.
    assign addr_ok = (int'(addr_reg) < NUM_REGS);

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr_reg) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    // Readback mux for the slot being checked.
    always_comb begin
        slot_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(addr_reg) == i) begin
                slot_sel = slot_rdata[i];
            end
        end
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic plus the grant pulse and the slot write enable.
    always_comb begin
        state_next  = state_reg;
        req_ready_o = '0;
        reg_wen_o   = '0;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    state_next = WRITE;
                    // Keep the accept pulse quiet while reset is held.
                    if (rst_ni) begin
                        req_ready_o[grant_idx] = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (addr_ok) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (int'(addr_reg) == i) begin
                            reg_wen_o[i] = 1'b1;
                        end
                    end
                    state_next = (RB_LAT == 0) ? CHECK : WAIT;
                end else begin
                    state_next = RESP;
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Transaction datapath: latch on grant, settle counter, readback compare.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_reg   <= '0;
            id_reg    <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        id_reg    <= grant_idx;
                        addr_reg  <= req_addr[grant_idx];
                        data_reg  <= req_data[grant_idx];
                        err_reg   <= 1'b0;
                        rdata_reg <= '0;
                        // The winner drops to lowest priority next time.
                        if (int'(grant_idx) == NUM_REQ - 1) begin
                            ptr_reg <= '0;
                        end else begin
                            ptr_reg <= grant_idx + ID_W'(1);
                        end
                    end
                end
                WRITE: begin
                    cnt_reg <= CNT_LOAD;
                    if (!addr_ok) begin
                        err_reg   <= 1'b1;
                        rdata_reg <= '0;
                    end
                end
                WAIT: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                CHECK: begin
                    rdata_reg <= slot_sel;
                    err_reg   <= (slot_sel != data_reg);
                end
                default: begin
                end
            endcase
        end
    end

    assign reg_wdata_o = data_reg;
    assign rsp_valid_o = (state_reg == RESP);
    assign busy_o      = (state_reg != IDLE);
    // Response fields read as zero unless a response is being offered.
    assign rsp_id_o    = rsp_valid_o ? id_reg    : '0;
    assign rsp_err_o   = rsp_valid_o ? err_reg   : 1'b0;
    assign rsp_rdata_o = rsp_valid_o ? rdata_reg : '0;

endmodule

// File: doc/custom_reg_arbiter.md
CUSTOM_REG_ARBITER -- requirements
Module: custom_reg_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of write requesters.
REQ-002 The block SHALL have parameter NUM_REGS, default 3, meaning the number of IP register slots.
REQ-003 The block SHALL have parameter DATA_W, default 32, meaning the slot data width.
REQ-004 The block SHALL have parameter RB_LAT, default 2, meaning the cycles from the write-enable pulse to a valid readback.
REQ-005 The block SHALL have port clk_i, input, 1 bit, the single clock.
REQ-006 The block SHALL have port rst_ni, input, 1 bit, the reset, which is asynchronous and active-low.
REQ-007 The block SHALL have port req_valid_i, input, NUM_REQ bits, a per-requester write request.
REQ-008 The block SHALL have port req_addr_i, input, NUM_REQ*2 bits, a per-requester slot index.
REQ-009 The block SHALL have port req_data_i, input, NUM_REQ*DATA_W bits, per-requester write data.
REQ-010 The block SHALL have port req_ready_o, output, NUM_REQ bits, a one-hot request-accept pulse.
REQ-011 The block SHALL have port reg_wdata_o, output, DATA_W bits, the data driven to the IP.
REQ-012 The block SHALL have port reg_wen_o, output, NUM_REGS bits, the one-hot slot write enable.
REQ-013 The block SHALL have port reg_rdata_i, input, NUM_REGS*DATA_W bits, the IP slot readback.
REQ-014 The block SHALL have port rsp_valid_o, output, 1 bit, which indicates that a response is pending.
REQ-015 The block SHALL have port rsp_ready_i, input, 1 bit, the response accept.
REQ-016 The block SHALL have port rsp_id_o, output, clog2(NUM_REQ) bits, which carries the index of the granted requester.
REQ-017 The block SHALL have port rsp_err_o, output, 1 bit, which flags a bad address or a readback mismatch.
REQ-018 The block SHALL have port rsp_rdata_o, output, DATA_W bits, which carries the captured readback.
REQ-019 The block SHALL have port busy_o, output, 1 bit, which is high whenever the state is not IDLE.

Function
REQ-020 The FSM SHALL have the states IDLE, WRITE, WAIT, CHECK and RESP, and SHALL handle exactly one transaction at a time.
REQ-021 In IDLE with any req_valid_i bit high, the arbiter SHALL select the winner round-robin, starting from the requester after the last grant (requester 0 after reset).
REQ-022 In the same cycle, the block SHALL pulse req_ready_o for the winner only, latch its id, addr and data, and move to WRITE.
REQ-023 The round-robin pointer SHALL update only on a grant, and a requester that is granted SHALL have lowest priority in the next arbitration.
REQ-024 In WRITE with addr < NUM_REGS, the block SHALL assert reg_wen_o[addr] for exactly one cycle, drive reg_wdata_o with the latched data, and move to WAIT.
REQ-025 In WRITE with addr >= NUM_REGS, the block SHALL assert no reg_wen_o bit, set the error flag, set the readback to 0, and go directly to RESP.
REQ-026 WAIT SHALL count RB_LAT cycles and then move to CHECK; the count SHALL reload on every entry to WAIT.
REQ-027 CHECK SHALL capture slot addr of reg_rdata_i into rsp_rdata_o, set the error flag if it differs from the written data, and move to RESP after one cycle.
REQ-028 In RESP, rsp_valid_o SHALL be high, and rsp_id_o, rsp_err_o and rsp_rdata_o SHALL be stable until rsp_ready_i is sampled high.
REQ-029 When rsp_ready_i is sampled high in RESP, the block SHALL return to IDLE, and arbitration SHALL occur no earlier than the next cycle.
REQ-030 req_valid_i changes during a transaction SHALL be ignored, and no requester SHALL be dropped: a requester that holds valid SHALL be granted within NUM_REQ transactions.
REQ-031 Outside WRITE, reg_wen_o SHALL be 0; outside IDLE, req_ready_o SHALL be 0.
REQ-032 The worst-case latency from grant to rsp_valid_o SHALL be RB_LAT+3 cycles.

Reset
REQ-033 While rst_ni is low, the state SHALL be IDLE, the round-robin pointer SHALL be 0, and every output SHALL be 0, including req_ready_o, reg_wen_o, reg_wdata_o, rsp_* and busy_o.
REQ-034 A reset asserted mid-transaction SHALL abort the transaction immediately, issue no further reg_wen_o, and produce no response after the reset is released.

Verification
REQ-035 The bench SHALL cover a single write: req 1 writes addr 2 with 0xA5A5_0001, the IP echoes the data -> reg_wen_o=3'b100 for one cycle, then after RB_LAT+2 cycles rsp_valid_o=1, id=1, err=0, rdata=0xA5A5_0001.
REQ-036 The bench SHALL cover contention: all 4 requesters valid continuously from reset -> grants 0,1,2,3,0 in order, each followed by exactly one response.
REQ-037 The bench SHALL cover a bad address: req 0 writes addr 3 -> no reg_wen_o pulse, and the response has err=1, rdata=0.
REQ-038 The bench SHALL cover a readback mismatch: the IP returns 0x1 for a write of 0xFF -> err=1, rdata=0x1.
REQ-039 The bench SHALL cover backpressure: rsp_ready_i held low for 10 cycles -> rsp_* stable, busy_o=1, and no new req_ready_o.
REQ-040 The bench SHALL cover reset in WAIT: rst_ni low for 2 cycles -> all outputs 0 and IDLE; a following request to req 2 is granted first.
